// File: rtl/simon_seq_engine_if.sv
// Game-side signal bundle of the Simon sequencer: player/RNG inputs and
// Simon's display and status outputs.
interface simon_seq_engine_if #(
  parameter int BTN_W = 2,
  parameter int LEN_W = 5
);
  logic             start;
  logic [BTN_W-1:0] rand_num;
  logic [BTN_W-1:0] player_num;
  logic             player_pressed;
  logic             simon_turn;
  logic [BTN_W-1:0] simon_num;
  logic             simon_pressed;
  logic [LEN_W-1:0] round_len;
  logic [LEN_W-1:0] score;
  logic             game_over;
  logic             game_won;

  modport master (
    output start, rand_num, player_num, player_pressed,
    input  simon_turn, simon_num, simon_pressed, round_len, score, game_over, game_won
  );

  modport slave (
    input  start, rand_num, player_num, player_pressed,
    output simon_turn, simon_num, simon_pressed, round_len, score, game_over, game_won
  );
endinterface

// File: rtl/simon_seq_engine.sv
// Simon game sequencer: grows a random sequence one step per round, plays it
// back as timed pulses and checks the player's presses against it.
module simon_seq_engine #(
  parameter int NUM_BUTTONS   = 4,
  parameter int BTN_W         = 2,
  parameter int MAX_LEN       = 16,
  parameter int ON_TICKS      = 30,
  parameter int OFF_TICKS     = 30,
  parameter int TIMEOUT_TICKS = 120,
  parameter int CNT_W         = 7,
  parameter int LEN_W         = 5
) (
  input logic clk,
  input logic reset,
  simon_seq_engine_if.slave bus
);
  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(OFF_TICKS - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [LEN_W-1:0] LEN_WIN   = LEN_W'(MAX_LEN);
  localparam logic [BTN_W:0]   NUM_WIDE  = (BTN_W + 1)'(NUM_BUTTONS);
  // Truncated subtrahend; modulo-2^BTN_W subtraction still yields x-NUM_BUTTONS.
  localparam logic [BTN_W-1:0] NUM_BTN   = BTN_W'(NUM_BUTTONS);

  typedef enum logic [2:0] {
    IDLE, APPEND, PLAY_ON, PLAY_OFF, WAIT_IN, LOSE, WIN
  } stateT;

  stateT            state, stateNext;
  logic [LEN_W-1:0] len, lenNext;
  logic [LEN_W-1:0] idx, idxNext;
  logic [LEN_W-1:0] score, scoreNext;
  logic [CNT_W-1:0] timer, timerNext;
  logic             memWe;
  logic [BTN_W-1:0] foldVal;
  logic [BTN_W-1:0] memQ;
  logic [BTN_W-1:0] expectReg;
  logic [BTN_W-1:0] simonNumReg;
  logic [BTN_W-1:0] mem [DEPTH];

  assign foldVal = ({1'b0, bus.rand_num} >= NUM_WIDE) ? bus.rand_num - NUM_BTN : bus.rand_num;

  // Read of the step addressed next cycle, forwarding the value being appended.
  assign memQ = (memWe && (len[ADDR_W-1:0] == idxNext[ADDR_W-1:0]))
              ? foldVal : mem[idxNext[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (memWe) mem[len[ADDR_W-1:0]] <= foldVal;
    expectReg <= memQ;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      len         <= '0;
      idx         <= '0;
      score       <= '0;
      timer       <= '0;
      simonNumReg <= '0;
    end else begin
      state <= stateNext;
      len   <= lenNext;
      idx   <= idxNext;
      score <= scoreNext;
      timer <= timerNext;
      if (stateNext == PLAY_ON) simonNumReg <= memQ;
    end
  end

  always_comb begin
    stateNext = state;
    lenNext   = len;
    idxNext   = idx;
    scoreNext = score;
    timerNext = timer;
    memWe     = 1'b0;
    case (state)
      IDLE, LOSE, WIN: begin
        if (bus.start) begin
          stateNext = APPEND;
          lenNext   = '0;
          scoreNext = '0;
          idxNext   = '0;
        end
      end
      APPEND: begin
        memWe     = 1'b1;
        lenNext   = len + LEN_W'(1);
        idxNext   = '0;
        timerNext = '0;
        stateNext = PLAY_ON;
      end
      PLAY_ON: begin
        if (timer == ON_LAST) begin
          timerNext = '0;
          stateNext = PLAY_OFF;
        end else begin
          timerNext = timer + CNT_W'(1);
        end
      end
      PLAY_OFF: begin
        if (timer == OFF_LAST) begin
          timerNext = '0;
          if (idx == len - LEN_W'(1)) begin
            idxNext   = '0;
            stateNext = WAIT_IN;
          end else begin
            idxNext   = idx + LEN_W'(1);
            stateNext = PLAY_ON;
          end
        end else begin
          timerNext = timer + CNT_W'(1);
        end
      end
      WAIT_IN: begin
        // A press outranks a timeout landing on the same cycle.
        if (bus.player_pressed) begin
          if (bus.player_num != expectReg) begin
            stateNext = LOSE;
          end else if (idx == len - LEN_W'(1)) begin
            scoreNext = len;
            stateNext = (len == LEN_WIN) ? WIN : APPEND;
          end else begin
            idxNext   = idx + LEN_W'(1);
            timerNext = '0;
          end
        end else if (timer == WAIT_LAST) begin
          stateNext = LOSE;
        end else begin
          timerNext = timer + CNT_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.simon_turn    = (state == APPEND) || (state == PLAY_ON) || (state == PLAY_OFF);
  assign bus.simon_pressed = (state == PLAY_ON);
  assign bus.simon_num     = simonNumReg;
  assign bus.round_len     = len;
  assign bus.score         = score;
  assign bus.game_over     = (state == LOSE);
  assign bus.game_won      = (state == WIN);
endmodule
